// File: rtl/rev_cnot_bist.sv
// rev_cnot_bist: exhaustive self-test of a CNOT ladder and its prefix-XOR inverse.
// Every WIDTH-bit vector is pushed through forward then inverse stages and compared with itself.
`default_nettype none

module rev_cnot_bist #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inj_mask,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic             first_err_vld,
  output logic [WIDTH-1:0] first_err_vec,
  output logic [WIDTH-1:0] fwd_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] cnt_q;
  logic [1:0]       drain_q;
  logic             busy_q, done_q, pass_q;
  logic [WIDTH:0]   err_q;
  logic             first_vld_q;
  logic [WIDTH-1:0] first_vec_q;

  logic             valid0_q, valid1_q, valid2_q;
  logic [WIDTH-1:0] v_q, v_d1_q, v_d2_q;
  logic [WIDTH-1:0] fwd_q, fwd_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] low_mask;
  logic             mismatch;
  logic [WIDTH:0]   err_d;

  assign fwd_d = v_q ^ {v_q[WIDTH-2:0], 1'b0};

  // The injection mask acts on the live S1 output, so it is applied after the register.
  assign fwd_out = fwd_q ^ inj_mask;

  always_comb begin
    low_mask = '0;
    r_d      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      low_mask[i] = 1'b1;
      r_d[i]      = ^(fwd_out & low_mask);
    end
  end

  assign mismatch = valid2_q && (r_q != v_d2_q);
  assign err_d    = err_q + {{WIDTH{1'b0}}, mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      v_d1_q   <= '0;
      v_d2_q   <= '0;
      fwd_q    <= '0;
      r_q      <= '0;
    end else begin
      valid1_q <= valid0_q;
      valid2_q <= valid1_q;
      v_d1_q   <= v_q;
      v_d2_q   <= v_d1_q;
      fwd_q    <= fwd_d;
      r_q      <= r_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      drain_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      first_vld_q <= 1'b0;
      first_vec_q <= '0;
      valid0_q    <= 1'b0;
      v_q         <= '0;
    end else begin
      done_q <= 1'b0;
      if (mismatch) begin
        err_q <= err_d;
        if (!first_vld_q) begin
          first_vld_q <= 1'b1;
          first_vec_q <= v_d2_q;
        end
      end
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start) begin
            state_q     <= S_RUN;
            busy_q      <= 1'b1;
            cnt_q       <= '0;
            err_q       <= '0;
            first_vld_q <= 1'b0;
            first_vec_q <= '0;
            pass_q      <= 1'b0;
          end
        end
        S_RUN: begin
          v_q      <= cnt_q;
          valid0_q <= 1'b1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == {WIDTH{1'b1}}) begin
            state_q <= S_DRAIN;
            drain_q <= '0;
          end
        end
        S_DRAIN: begin
          valid0_q <= 1'b0;
          drain_q  <= drain_q + 2'd1;
          // Third drain edge also retires the last compare, so pass uses err_d.
          if (drain_q == 2'd2) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vld = first_vld_q;
  assign first_err_vec = first_vec_q;

endmodule

`default_nettype wire

// File: tb/tb_rev_cnot_bist.sv
// Bench for rev_cnot_bist (WIDTH=4): fwd_out table, reset, held start, single-fault and random fault runs.
`default_nettype none

module tb_rev_cnot_bist;

  localparam int W = 4;
  localparam int NV = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] inj_mask = '0;
  logic         busy, done, pass, first_err_vld;
  logic [W:0]   err_count;
  logic [W-1:0] first_err_vec, fwd_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] mask_tbl [NV];
  logic [W-1:0] obs_fwd  [NV];

  typedef struct {
    logic [W-1:0] vec;
    logic [W-1:0] exp_fwd;
  } fwd_vec_t;

  fwd_vec_t fwd_tbl [7];

  rev_cnot_bist #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .inj_mask      (inj_mask),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_vld (first_err_vld),
    .first_err_vec (first_err_vec),
    .fwd_out       (fwd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Since the inverse ladder is linear and bijective, vector v fails exactly when its mask is nonzero.
  task automatic run_masked(input string tag);
    int done_cnt, done_edge, busy_err, fwd_err, exp_err, exp_first;
    logic [W-1:0] v;
    done_cnt = 0; done_edge = -1; busy_err = 0; fwd_err = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1 inj_mask = (n >= 2 && n <= 17) ? mask_tbl[n-2] : '0;
      @(negedge clk);
      if (n >= 2 && n <= 17) obs_fwd[n-2] = fwd_out;
      if (done) begin done_cnt++; done_edge = n; end
      if (busy !== (n <= 18)) busy_err++;
    end
    exp_err = 0; exp_first = -1;
    for (int k = 0; k < NV; k++) begin
      v = k[W-1:0];
      if (obs_fwd[k] !== (((v ^ (v << 1)) & 4'hF) ^ mask_tbl[k])) fwd_err++;
      if (mask_tbl[k] != 0) begin
        exp_err++;
        if (exp_first < 0) exp_first = k;
      end
    end
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_edge"}, done_edge, 19);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_fwd"}, fwd_err, 0);
    check({tag, "_err_count"}, err_count, exp_err);
    check({tag, "_pass"}, pass, exp_err == 0);
    check({tag, "_first_vld"}, first_err_vld, exp_err != 0);
    if (exp_err != 0) check({tag, "_first_vec"}, first_err_vec, exp_first);
  endtask

  initial begin
    int hold_dones;
    fwd_tbl[0] = '{4'hB, 4'hD};
    fwd_tbl[1] = '{4'h5, 4'hF};
    fwd_tbl[2] = '{4'h0, 4'h0};
    fwd_tbl[3] = '{4'hF, 4'h1};
    fwd_tbl[4] = '{4'h9, 4'hB};
    fwd_tbl[5] = '{4'h8, 4'h8};
    fwd_tbl[6] = '{4'h1, 4'h3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    rst = 1'b0;

    // Reset in the middle of a run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_err", err_count, 0);
    check("midrst_fvld", first_err_vld, 0);
    check("midrst_fvec", first_err_vec, 0);
    check("midrst_fwd", fwd_out, 0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) mask_tbl[k] = '0;
    run_masked("clean");
    for (int i = 0; i < 7; i++)
      check($sformatf("fwd_tbl_%0h", fwd_tbl[i].vec), obs_fwd[fwd_tbl[i].vec], fwd_tbl[i].exp_fwd);

    for (int k = 0; k < NV; k++) mask_tbl[k] = 4'b0100;
    run_masked("mask4");

    for (int k = 0; k < NV; k++) mask_tbl[k] = '0;
    mask_tbl[9] = 4'b0001;
    run_masked("one9");

    // Start held high: one run, return to IDLE, then a second run.
    hold_dones = 0;
    @(negedge clk);
    start = 1'b1;
    inj_mask = 4'b0100;
    for (int n = 0; n <= 44; n++) begin
      @(posedge clk);
      #1 if (n == 20) inj_mask = '0;
      @(negedge clk);
      if (done) hold_dones++;
      if (n == 19) begin
        check("hold_done1", done, 1);
        check("hold_err1", err_count, 16);
        check("hold_pass1", pass, 0);
      end
      if (n == 22) begin
        check("hold_cleared_err", err_count, 0);
        check("hold_cleared_fvld", first_err_vld, 0);
      end
      if (n == 40) begin
        check("hold_done2", done, 1);
        check("hold_err2", err_count, 0);
        check("hold_pass2", pass, 1);
      end
    end
    start = 1'b0;
    check("hold_done_total", hold_dones, 2);
    repeat (25) @(posedge clk);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < NV; k++)
        mask_tbl[k] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : '0;
      run_masked($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
